// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - unified instruction/data memory with fetch and data ports
//
// Fetch port (read-only) and data port (read/write with byte enables) share one
// word array. Both ports return registered read data with a one-cycle valid
// pulse and an out-of-range fault flag. After reset a sequencer optionally
// zeroes the whole array while busy is high.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_req, i_addr             fetch request and word address
//   i_data, i_valid, i_fault  fetched word, valid pulse, address fault
//   d_read, d_write, d_addr   data read/write requests and word address
//   d_wdata, d_be             write data and per-byte enables
//   d_rdata, d_valid, d_fault read word, valid pulse, address fault
//   busy                      clear sequence running; requests are dropped

module dual_port_ram #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 128,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_data,
    output logic                  i_valid,
    output logic                  i_fault,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  d_fault,
    output logic                  busy
);

    localparam int NB = DATA_W / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state;
    logic [IW-1:0]     clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    // Full-width compare so addresses beyond DEPTH never alias into the array.
    logic i_oor;
    logic d_oor;
    assign i_oor = {1'b0, i_addr} >= (ADDR_W+1)'(DEPTH);
    assign d_oor = {1'b0, d_addr} >= (ADDR_W+1)'(DEPTH);

    // Out-of-range addresses index word 0 so the array is never read past its end;
    // the result is discarded in that case anyway.
    logic [IW-1:0] i_idx;
    logic [IW-1:0] d_idx;
    assign i_idx = i_oor ? '0 : i_addr[IW-1:0];
    assign d_idx = d_oor ? '0 : d_addr[IW-1:0];

    logic run;
    logic d_wr_ok;
    assign run     = (state == ST_RUN);
    assign d_wr_ok = run && d_write && !d_oor;

    // Word as it will look after this edge's write: enabled bytes come from
    // d_wdata, the rest from the array. Readers of the written address see this.
    logic [DATA_W-1:0] d_merged;
    always_comb begin
        d_merged = mem[d_idx];
        for (int k = 0; k < NB; k++) begin
            if (d_be[k]) begin
                d_merged[8*k +: 8] = d_wdata[8*k +: 8];
            end
        end
    end

    logic [DATA_W-1:0] i_word;
    logic [DATA_W-1:0] d_word;
    always_comb begin
        i_word = mem[i_idx];
        if (d_wr_ok && (i_addr == d_addr)) begin
            i_word = d_merged;
        end
        d_word = d_wr_ok ? d_merged : mem[d_idx];
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            clr_ptr <= '0;
            busy    <= 1'b1;
            i_data  <= '0;
            i_valid <= 1'b0;
            i_fault <= 1'b0;
            d_rdata <= '0;
            d_valid <= 1'b0;
            d_fault <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            i_fault <= 1'b0;
            d_valid <= 1'b0;
            d_fault <= 1'b0;
            case (state)
                ST_INIT: begin
                    if ((CLEAR_ON_RESET == 0) || (clr_ptr == IW'(DEPTH - 1))) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_req) begin
                        i_valid <= 1'b1;
                        i_fault <= i_oor;
                        i_data  <= i_oor ? '0 : i_word;
                    end
                    if (d_read) begin
                        d_valid <= 1'b1;
                        d_fault <= d_oor;
                        d_rdata <= d_oor ? '0 : d_word;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array writes: clear sequencer while initialising, byte-enabled data
    // writes while running. The array itself carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_INIT) && (CLEAR_ON_RESET != 0)) begin
            mem[clr_ptr] <= '0;
        end else if (!rst && d_wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (d_be[k]) begin
                    mem[d_idx][8*k +: 8] <= d_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - self-checking bench for dual_port_ram

module tb_dual_port_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic [15:0] i_data;
    logic        i_valid;
    logic        i_fault;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [1:0]  d_be = '0;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        d_fault;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dual_port_ram #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(128), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid), .i_fault(i_fault),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_fault(d_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain word array plus expected output registers.
    logic [15:0] mm [128];
    logic        exp_iv, exp_if, exp_dv, exp_df;
    logic [15:0] exp_id, exp_dd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 128; a++) mm[a] = 16'h0000;
        exp_id = 16'h0000;
        exp_dd = 16'h0000;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    endtask

    // One running cycle: drive, update the model (write first, then reads), clock.
    task automatic cyc(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] wd, input logic [1:0] be);
        i_req = ir; i_addr = ia; d_read = dr; d_write = dw; d_addr = da; d_wdata = wd; d_be = be;
        if (dw && da < 16'd128) begin
            if (be[0]) mm[da[6:0]][7:0]  = wd[7:0];
            if (be[1]) mm[da[6:0]][15:8] = wd[15:8];
        end
        exp_iv = ir;
        exp_if = ir && (ia >= 16'd128);
        if (ir) exp_id = (ia < 16'd128) ? mm[ia[6:0]] : 16'h0000;
        exp_dv = dr;
        exp_df = dr && (da >= 16'd128);
        if (dr) exp_dd = (da < 16'd128) ? mm[da[6:0]] : 16'h0000;
        @(posedge clk);
        #1;
    endtask

    // Requests are held active through the whole clear; none may be accepted.
    task automatic wait_clear(input string tag);
        int n = 0;
        logic bad = 1'b0;
        i_req = 1; i_addr = 0; d_read = 1; d_write = 1; d_addr = 0; d_wdata = 16'hFFFF; d_be = 2'b11;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (i_valid || d_valid) bad = 1'b1;
        end
        idle_inputs();
        chk({tag, "_busy_cycles"}, n, 128);
        chk({tag, "_dropped_reqs"}, bad, 0);
        model_clear();
    endtask

    typedef struct packed {
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        eiv;
        logic [15:0] eid;
        logic        eif;
        logic        edv;
        logic [15:0] edd;
        logic        edf;
    } vec_t;

    vec_t vt [13];

    initial begin
        //          ir  ia         dr  dw  da        wd        be     eiv eid       eif  edv edd       edf
        vt[0]  = '{1'b0, 16'd0,    1'b0, 1'b1, 16'd5,   16'hAAAA, 2'b11, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[1]  = '{1'b0, 16'd0,    1'b1, 1'b0, 16'd5,   16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 1'b0};
        vt[2]  = '{1'b0, 16'd0,    1'b0, 1'b1, 16'd7,   16'h1234, 2'b11, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[3]  = '{1'b0, 16'd0,    1'b1, 1'b1, 16'd7,   16'hABCD, 2'b01, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h12CD, 1'b0};
        vt[4]  = '{1'b1, 16'd7,    1'b0, 1'b0, 16'd0,   16'h0000, 2'b00, 1'b1, 16'h12CD, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[5]  = '{1'b1, 16'd9,    1'b0, 1'b1, 16'd9,   16'h5A5A, 2'b11, 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[6]  = '{1'b1, 16'd128,  1'b0, 1'b1, 16'd200, 16'hFFFF, 2'b11, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
        vt[7]  = '{1'b0, 16'd0,    1'b1, 1'b0, 16'd200, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
        vt[8]  = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 16'd128, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1};
        vt[9]  = '{1'b1, 16'd9,    1'b1, 1'b1, 16'd9,   16'h11FF, 2'b10, 1'b1, 16'h115A, 1'b0, 1'b1, 16'h115A, 1'b0};
        vt[10] = '{1'b1, 16'd72,   1'b0, 1'b0, 16'd0,   16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[11] = '{1'b1, 16'd5,    1'b0, 1'b0, 16'd0,   16'h0000, 2'b00, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 1'b0};
        vt[12] = '{1'b0, 16'd0,    1'b0, 1'b0, 16'd0,   16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};

        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_i_valid", i_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_i_data", i_data, 16'h0000);
        chk("rst_d_rdata", d_rdata, 16'h0000);
        chk("rst_faults", {i_fault, d_fault}, 0);
        rst = 0;
        wait_clear("clear1");

        // Every word fetches as zero after the clear
        for (int a = 0; a < 128; a++) begin
            cyc(1, 16'(a), 0, 0, 0, 0, 0);
            chk($sformatf("sweep_data_%0d", a), {i_valid, i_fault, i_data}, {1'b1, 1'b0, 16'h0000});
        end

        // Directed vectors
        for (int v = 0; v < 13; v++) begin
            cyc(vt[v].ir, vt[v].ia, vt[v].dr, vt[v].dw, vt[v].da, vt[v].wd, vt[v].be);
            chk($sformatf("vec%0d_i_valid", v), i_valid, vt[v].eiv);
            if (vt[v].eiv) begin
                chk($sformatf("vec%0d_i_data", v), i_data, vt[v].eid);
                chk($sformatf("vec%0d_i_fault", v), i_fault, vt[v].eif);
            end
            chk($sformatf("vec%0d_d_valid", v), d_valid, vt[v].edv);
            if (vt[v].edv) begin
                chk($sformatf("vec%0d_d_rdata", v), d_rdata, vt[v].edd);
                chk($sformatf("vec%0d_d_fault", v), d_fault, vt[v].edf);
            end
        end
        chk("i_data_hold", i_data, 16'hAAAA);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [15:0] ia, da;
            ia = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 135));
            da = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 135));
            if ($urandom_range(0, 3) == 0) ia = da;
            cyc(1'($urandom), ia, 1'($urandom), 1'($urandom), da, 16'($urandom), 2'($urandom));
            chk("rnd_busy", busy, 0);
            chk("rnd_i_valid", i_valid, exp_iv);
            chk("rnd_i_data", i_data, exp_id);
            if (exp_iv) chk("rnd_i_fault", i_fault, exp_if);
            chk("rnd_d_valid", d_valid, exp_dv);
            if (exp_dv) begin
                chk("rnd_d_rdata", d_rdata, exp_dd);
                chk("rnd_d_fault", d_fault, exp_df);
            end
        end

        // Reset during a pending read: valid drops at once
        cyc(0, 0, 1, 0, 16'd5, 0, 0);
        chk("pend_d_valid", d_valid, 1);
        rst = 1;
        #1;
        chk("async_d_valid", d_valid, 0);
        chk("async_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 0;

        // Reset again mid-clear, after 40 clear cycles
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("mid_init_busy", busy, 1);
        rst = 1;
        #1;
        chk("mid_init_rst_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 0;
        wait_clear("clear2");

        cyc(1, 16'd9, 1, 0, 16'd7, 0, 0);
        chk("post_clear_i", {i_valid, i_data}, {1'b1, 16'h0000});
        chk("post_clear_d", {d_valid, d_rdata}, {1'b1, 16'h0000});
        cyc(1, 16'd127, 0, 0, 0, 0, 0);
        chk("post_clear_last", {i_valid, i_fault, i_data}, {1'b1, 1'b0, 16'h0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
